// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the serial add/subtract unit.
//   state_t      : controller states (IDLE / RUN / DONE)
//   smax(width)  : largest signed value representable in 'width' bits
//   smin(width)  : most negative signed value in 'width' bits (bit pattern)
// Both helpers return a 64-bit pattern; callers size-cast to their width, so
// they cover widths up to 64 bits.
// ----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [63:0] smax(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// ----------------------------------------------------------------------------
// ripple_carry_adder
// Purely combinational WIDTH-bit ripple-carry adder used as the per-cycle
// slice adder of serial_addsub_n.
// Ports:
//   a, b     : addends
//   cin      : carry into bit 0
//   sum      : a + b + cin (low WIDTH bits)
//   cout     : carry out of the top bit
//   msb_cin  : carry into the top bit (needed for signed-overflow detection)
// ----------------------------------------------------------------------------
module ripple_carry_adder #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [WIDTH:0] carry;

    // The carry chain is built in one combinational process so the chain is
    // evaluated in order rather than as a self-referencing vector of assigns.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
            assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
        end
    endgenerate

    assign cout    = carry[WIDTH];
    assign msb_cin = carry[WIDTH-1];

endmodule

// File: rtl/serial_addsub_n.sv
// ----------------------------------------------------------------------------
// serial_addsub_n
// Two's-complement add/subtract computed STEP bits per clock. Operands are
// accepted through a valid/ready handshake; the result and flags are held in
// output registers until the consumer accepts them.
//
// Parameters:
//   WIDTH : operand/result width (>= 2)
//   STEP  : bits processed per cycle, must divide WIDTH
//
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   IN_VALID   : operand request            IN_READY  : idle, accepts operands
//   A, B       : operands                   SUB       : 0 = A+B, 1 = A-B
//   OUT_VALID  : result registers valid     OUT_READY : consumer accepts result
//   S          : result                     CO        : raw carry out of MSB
//   OVF        : signed overflow            ZERO      : S == 0
//   NEG        : S[WIDTH-1]
//
// Build option:
//   SERIAL_ADDSUB_SATURATE_EN : when defined, an overflowing result is clamped
//   to the signed limit on the side of A's sign; OVF and CO are still the raw
//   values, ZERO/NEG follow the clamped S. Undefined: results wrap.
// ----------------------------------------------------------------------------
module serial_addsub_n
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF,
    output logic             ZERO,
    output logic             NEG
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("serial_addsub_n: WIDTH must be >= 2 and STEP must divide WIDTH");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] s_reg;
    logic             co_reg, ovf_reg, zero_reg, neg_reg;

    logic [STEP-1:0]  slice_sum;
    logic             slice_cout, slice_msb_cin;
    logic [WIDTH-1:0] res_shift, s_final;
    logic             ovf_final, last_slice;

    // B has already been inverted at capture for subtraction, and the initial
    // carry supplies the +1, so the slice adder only ever adds.
    ripple_carry_adder #(
        .WIDTH(STEP)
    ) u_slice (
        .a      (a_sh_reg[STEP-1:0]),
        .b      (b_sh_reg[STEP-1:0]),
        .cin    (carry_reg),
        .sum    (slice_sum),
        .cout   (slice_cout),
        .msb_cin(slice_msb_cin)
    );

    // Sum slices enter at the top of the result register; after N slices the
    // first slice has reached bit 0.
    generate
        if (STEP == WIDTH) begin : g_res_whole
            assign res_shift = slice_sum;
        end else begin : g_res_shift
            assign res_shift = {slice_sum, res_reg[WIDTH-1:STEP]};
        end
    endgenerate

    assign last_slice = (cnt_reg == LAST_CNT);
    // On the last slice the adder is working on the operand MSBs, so its
    // internal carries are exactly the MSB carry-in / carry-out.
    assign ovf_final  = slice_msb_cin ^ slice_cout;

`ifdef SERIAL_ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(smin(WIDTH));
    logic a_sign;
    // The remaining A slice during the last step holds A's top bits.
    assign a_sign  = a_sh_reg[STEP-1];
    assign s_final = ovf_final ? (a_sign ? SAT_MIN : SAT_MAX) : res_shift;
`else
    assign s_final = res_shift;
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (IN_VALID)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (OUT_READY)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (IN_VALID) begin
                        a_sh_reg  <= A;
                        b_sh_reg  <= B ^ {WIDTH{SUB}};
                        carry_reg <= SUB;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> STEP;
                    b_sh_reg  <= b_sh_reg >> STEP;
                    res_reg   <= res_shift;
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_slice) begin
                        s_reg    <= s_final;
                        co_reg   <= slice_cout;
                        ovf_reg  <= ovf_final;
                        zero_reg <= (s_final == '0);
                        neg_reg  <= s_final[WIDTH-1];
                    end
                end
                default: begin
                    // DONE: result registers hold until the consumer accepts.
                end
            endcase
        end
    end

    assign IN_READY  = (state_reg == IDLE);
    assign OUT_VALID = (state_reg == DONE);
    assign S         = s_reg;
    assign CO        = co_reg;
    assign OVF       = ovf_reg;
    assign ZERO      = zero_reg;
    assign NEG       = neg_reg;

endmodule
